// File: rtl/fft_stage_sequencer.sv
// Read/write-back address scheduler for an in-place radix-2 DIT FFT.
// Walks LOG2N stages of N/2 butterflies and drains the butterfly pipe between stages.
module fft_stage_sequencer #(
  parameter int unsigned LOG2N  = 3,
  parameter int unsigned BF_LAT = 2
) (
  input  logic             clk2,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N - 1);
  localparam logic [LOG2N-2:0] LAST_BFLY  = '1;

  state_t           state_q, state_d;
  logic [LOG2N-1:0] stage_q, stage_d;
  logic [LOG2N-2:0] bfly_q, bfly_d;
  logic [LOG2N-1:0] rda_q, rda_d, rdb_q, rdb_d;
  logic [LOG2N-2:0] tw_q, tw_d;

  logic [BF_LAT-1:0] vld_q;
  logic [LOG2N-1:0]  pa_q [BF_LAT];
  logic [LOG2N-1:0]  pb_q [BF_LAT];

  logic             drain_ok;
  logic [LOG2N-1:0] bf_ext, span, pos, grp, addr_a;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    // The pipe is empty on the next cycle once only its output slot may still be valid.
    drain_ok = 1'b1;
    for (int unsigned k = 0; k + 1 < BF_LAT; k++) begin
      if (vld_q[k]) drain_ok = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        stage_d = '0;
        bfly_d  = '0;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (bfly_q == LAST_BFLY) state_d = S_DRAIN;
        else                     bfly_d  = bfly_q + 1'b1;
      end
      S_DRAIN: begin
        if (drain_ok) begin
          if (stage_q == LAST_STAGE) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            stage_d = stage_q + 1'b1;
            bfly_d  = '0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        stage_d = '0;
        bfly_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Addresses are computed from next-cycle counters so they register alongside rd_en.
  always_comb begin
    bf_ext = {1'b0, bfly_d};
    span   = LOG2N'(1) << stage_d;
    pos    = bf_ext & (span - LOG2N'(1));
    grp    = bf_ext >> stage_d;
    addr_a = ((grp << stage_d) << 1) | pos;
    rda_d  = rda_q;
    rdb_d  = rdb_q;
    tw_d   = tw_q;
    if (state_d == S_RUN) begin
      rda_d = addr_a;
      rdb_d = addr_a + span;
      tw_d  = (LOG2N-1)'(pos << (LAST_STAGE - stage_d));
    end
  end

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      bfly_q  <= '0;
      rda_q   <= '0;
      rdb_q   <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
      rda_q   <= rda_d;
      rdb_q   <= rdb_d;
      tw_q    <= tw_d;
    end
  end

  // Address slots only load with valid data, so the output slot holds its last write-back pair.
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < BF_LAT; k++) begin
        pa_q[k] <= '0;
        pb_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= rd_en;
      if (rd_en) begin
        pa_q[0] <= rda_q;
        pb_q[0] <= rdb_q;
      end
      for (int unsigned k = 1; k < BF_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          pa_q[k] <= pa_q[k-1];
          pb_q[k] <= pb_q[k-1];
        end
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign rd_en     = (state_q == S_RUN);
  assign stage     = stage_q;
  assign rd_addr_a = rda_q;
  assign rd_addr_b = rdb_q;
  assign tw_addr   = tw_q;
  assign wr_en     = vld_q[BF_LAT-1];
  assign wr_addr_a = pa_q[BF_LAT-1];
  assign wr_addr_b = pb_q[BF_LAT-1];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: two configurations (N=8/lat 2 and N=16/lat 1) share stimulus
// and are compared every cycle against a timeline model built from stage/butterfly arithmetic.
module tb_fft_stage_sequencer;

  logic clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  logic rst_n, start;

  logic       d3_busy, d3_done, d3_rd_en, d3_wr_en;
  logic [2:0] d3_stage, d3_rda, d3_rdb, d3_wra, d3_wrb;
  logic [1:0] d3_tw;

  logic       d4_busy, d4_done, d4_rd_en, d4_wr_en;
  logic [3:0] d4_stage, d4_rda, d4_rdb, d4_wra, d4_wrb;
  logic [2:0] d4_tw;

  fft_stage_sequencer #(.LOG2N(3), .BF_LAT(2)) dut3 (
    .clk2(clk2), .rst_n(rst_n), .start(start), .busy(d3_busy), .done(d3_done),
    .stage(d3_stage), .rd_en(d3_rd_en), .rd_addr_a(d3_rda), .rd_addr_b(d3_rdb),
    .tw_addr(d3_tw), .wr_en(d3_wr_en), .wr_addr_a(d3_wra), .wr_addr_b(d3_wrb)
  );

  fft_stage_sequencer #(.LOG2N(4), .BF_LAT(1)) dut4 (
    .clk2(clk2), .rst_n(rst_n), .start(start), .busy(d4_busy), .done(d4_done),
    .stage(d4_stage), .rd_en(d4_rd_en), .rd_addr_a(d4_rda), .rd_addr_b(d4_rdb),
    .tw_addr(d4_tw), .wr_en(d4_wr_en), .wr_addr_a(d4_wra), .wr_addr_b(d4_wrb)
  );

  int checks = 0;
  int errors = 0;

  // Model state per configuration: cyc counts cycles since the start-sampling edge.
  int ml[2], mlat[2], act[2], cyc[2];
  int e_rd[2], e_wr[2], e_done[2], e_busy[2], e_stage[2];
  int h_rda[2], h_rdb[2], h_tw[2], h_wra[2], h_wrb[2];

  task automatic chk(input string tag, input int m, input integer obs, input integer exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d: observed=%0d expected=%0d", tag, m, obs, exp);
    end
  endtask

  function automatic void bfly_addr(input int n, input int s, input int k,
                                    output int a, output int b, output int tw);
    int span, g, j;
    span = 1 << s;
    g    = k / span;
    j    = k % span;
    a    = g * 2 * span + j;
    b    = a + span;
    tw   = j * (n / (2 * span));
  endfunction

  task automatic model_clear(input int m);
    act[m] = 0; cyc[m] = 0;
    e_rd[m] = 0; e_wr[m] = 0; e_done[m] = 0; e_busy[m] = 0; e_stage[m] = 0;
    h_rda[m] = 0; h_rdb[m] = 0; h_tw[m] = 0; h_wra[m] = 0; h_wrb[m] = 0;
  endtask

  task automatic model_eval(input int m);
    int n, h, p, s, k, c2, a, b, tw;
    n = 1 << ml[m];
    h = n / 2;
    p = h + mlat[m];
    e_rd[m] = 0; e_wr[m] = 0; e_done[m] = 0; e_busy[m] = 0; e_stage[m] = 0;
    if (act[m] != 0) begin
      e_busy[m] = 1;
      if (cyc[m] == ml[m] * p + 1) begin
        e_done[m]  = 1;
        e_stage[m] = ml[m] - 1;
      end else begin
        s = (cyc[m] - 1) / p;
        k = (cyc[m] - 1) % p;
        e_stage[m] = s;
        if (k < h) begin
          e_rd[m] = 1;
          bfly_addr(n, s, k, a, b, tw);
          h_rda[m] = a; h_rdb[m] = b; h_tw[m] = tw;
        end
      end
      c2 = cyc[m] - mlat[m];
      if (c2 >= 1) begin
        s = (c2 - 1) / p;
        k = (c2 - 1) % p;
        if (s < ml[m] && k < h) begin
          e_wr[m] = 1;
          bfly_addr(n, s, k, a, b, tw);
          h_wra[m] = a; h_wrb[m] = b;
        end
      end
    end
  endtask

  task automatic model_edge(input logic st, input logic rs);
    int p;
    for (int m = 0; m < 2; m++) begin
      p = (1 << (ml[m] - 1)) + mlat[m];
      if (!rs) begin
        model_clear(m);
      end else begin
        if (act[m] != 0) begin
          cyc[m]++;
          if (cyc[m] > ml[m] * p + 1) begin
            act[m] = 0;
            cyc[m] = 0;
          end
        end else if (st) begin
          act[m] = 1;
          cyc[m] = 1;
        end
        model_eval(m);
      end
    end
  endtask

  task automatic compare_all();
    integer o_busy, o_done, o_stage, o_rd, o_rda, o_rdb, o_tw, o_wr, o_wra, o_wrb;
    for (int m = 0; m < 2; m++) begin
      if (m == 0) begin
        o_busy = d3_busy; o_done = d3_done; o_stage = d3_stage; o_rd = d3_rd_en;
        o_rda = d3_rda; o_rdb = d3_rdb; o_tw = d3_tw; o_wr = d3_wr_en;
        o_wra = d3_wra; o_wrb = d3_wrb;
      end else begin
        o_busy = d4_busy; o_done = d4_done; o_stage = d4_stage; o_rd = d4_rd_en;
        o_rda = d4_rda; o_rdb = d4_rdb; o_tw = d4_tw; o_wr = d4_wr_en;
        o_wra = d4_wra; o_wrb = d4_wrb;
      end
      chk("busy",      m, o_busy,  e_busy[m]);
      chk("done",      m, o_done,  e_done[m]);
      chk("stage",     m, o_stage, e_stage[m]);
      chk("rd_en",     m, o_rd,    e_rd[m]);
      chk("rd_addr_a", m, o_rda,   h_rda[m]);
      chk("rd_addr_b", m, o_rdb,   h_rdb[m]);
      chk("tw_addr",   m, o_tw,    h_tw[m]);
      chk("wr_en",     m, o_wr,    e_wr[m]);
      chk("wr_addr_a", m, o_wra,   h_wra[m]);
      chk("wr_addr_b", m, o_wrb,   h_wrb[m]);
    end
  endtask

  task automatic step();
    logic st, rs;
    st = start;
    rs = rst_n;
    @(posedge clk2);
    model_edge(st, rs);
    #2;
    compare_all();
  endtask

  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_clear(0);
    model_clear(1);
    compare_all();
  endtask

  initial begin
    ml[0] = 3; mlat[0] = 2;
    ml[1] = 4; mlat[1] = 1;
    model_clear(0);
    model_clear(1);
    rst_n = 1'b0;
    start = 1'b0;

    // Reset state
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Single start pulse, then random start requests while busy
    repeat ($urandom_range(1, 3)) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (45) begin
      start = ($urandom_range(0, 3) == 0);
      step();
    end
    start = 1'b0;
    repeat (40) step();

    // start held high: back-to-back transforms
    start = 1'b1;
    repeat (120) step();
    start = 1'b0;
    repeat (40) step();

    // Abort mid stage 1 of the N=8 run, then restart from stage 0
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    async_reset();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (45) step();

    // Random start traffic with occasional asynchronous resets
    repeat (400) begin
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end
    start = 1'b0;
    repeat (45) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
